wide_add_seq: RTL

- Multi-precision add/subtract sequencer built around a single 32-bit ripple-carry adder instance (A, B, cIn in; 33-bit sum out).
- Accepts WORDS×32-bit operands through a valid/ready handshake and feeds the adder one word per clock, LSW first, registering the carry between words.
- Returns the wide result through a valid/ready output handshake.
- Sits between the ALU issue logic and the shared 32-bit adder datapath.

---
 rtl/wide_add_seq.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/wide_add_seq.sv
// wide_add_seq: multi-precision add/subtract sequencer.
// Streams WORDS x 32-bit operands through one 32-bit ripple-carry adder,
// LSW first, carrying between words in a register.
// Optional feature macro: WIDE_ADD_OVF_EN adds the signed-overflow output ovf.

// 32-bit ripple-carry adder with a 33-bit sum output.
module rca32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ci,
  output logic [32:0] sum
);
  logic [32:0] c;

  // Bitwise full-adder chain: carry ripples from bit 0 to bit 31.
  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = ci;
    for (int i = 0; i < 32; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
    sum[32] = c[32];
  end
endmodule

module wide_add_seq #(
  parameter int WORDS = 4,
  localparam int W    = 32 * WORDS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         cout,
`ifdef WIDE_ADD_OVF_EN
  output logic         ovf,
`endif
  output logic         busy
);
  localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state_q, state_d;
  logic [IDXW-1:0]        idx_q, idx_d;
  logic [WORDS-1:0][31:0] a_q, a_d;
  logic [WORDS-1:0][31:0] b_q, b_d;
  logic [WORDS-1:0][31:0] result_q, result_d;
  logic                   sub_q, sub_d;
  logic                   carry_q, carry_d;
  logic                   cout_q, cout_d;
`ifdef WIDE_ADD_OVF_EN
  logic                   ovf_q, ovf_d;
`endif

  logic [31:0] add_a, add_b;
  logic [32:0] add_sum;

  // Current word operands; subtraction feeds the inverted B word (carry seeded to 1).
  always_comb begin
    add_a = a_q[idx_q];
    add_b = sub_q ? ~b_q[idx_q] : b_q[idx_q];
  end

  rca32 u_add (
    .a   (add_a),
    .b   (add_b),
    .ci  (carry_q),
    .sum (add_sum)
  );

  // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    sub_d    = sub_q;
    carry_d  = carry_q;
    result_d = result_q;
    cout_d   = cout_q;
`ifdef WIDE_ADD_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          sub_d   = sub;
          carry_d = sub ? 1'b1 : cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        result_d[idx_q] = add_sum[31:0];
        carry_d         = add_sum[32];
        idx_d           = idx_q + 1'b1;
        if (idx_q == LAST) begin
          cout_d  = add_sum[32];
`ifdef WIDE_ADD_OVF_EN
          // Carry into the MSB recovered from the top-word sum bit.
          ovf_d   = (add_a[31] ^ add_b[31] ^ add_sum[31]) ^ add_sum[32];
`endif
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset; reset discards any in-flight op.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
`ifdef WIDE_ADD_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sub_q    <= sub_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
`ifdef WIDE_ADD_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = result_q;
  assign cout      = cout_q;
`ifdef WIDE_ADD_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule
